// File: rtl/bram_arbiter_pkg.sv
// Shared constants and types for the two-requester Block_RAM arbiter.
// The lock states are used only when BRAM_ARB_LOCK_EN is defined.
package bram_arbiter_pkg;

    localparam int BRAM_ADDR_W = 14;
    localparam int BRAM_DATA_W = 32;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } lock_state_t;

    // On a tie, the requester that did not win last time takes the slot.
    function automatic logic rr_winner(input logic last_id);
        return ~last_id;
    endfunction

endpackage

// File: rtl/bram_arb_rr2.sv
// Two-way round-robin grant with an optional lock/ownership FSM.
// The FSM is built only when BRAM_ARB_LOCK_EN is defined.
module bram_arb_rr2
    import bram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic RSTn,
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);

    logic rr_last_r;
    logic req0_s;
    logic req1_s;

`ifdef BRAM_ARB_LOCK_EN
    lock_state_t own_state_r;

    // Hide the non-owner's request while the other requester holds the lock
    always_comb begin
        req0_s = req0;
        req1_s = req1;
        case (own_state_r)
            OWN0:    req1_s = 1'b0;
            OWN1:    req0_s = 1'b0;
            default: begin
                req0_s = req0;
                req1_s = req1;
            end
        endcase
    end

    // Ownership is taken and released only by the owner's own accepted beats
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            own_state_r <= FREE;
        end else begin
            case (own_state_r)
                FREE: begin
                    if (gnt0 && lock0) begin
                        own_state_r <= OWN0;
                    end else if (gnt1 && lock1) begin
                        own_state_r <= OWN1;
                    end else begin
                        own_state_r <= FREE;
                    end
                end
                OWN0: begin
                    if (gnt0 && !lock0) begin
                        own_state_r <= FREE;
                    end else begin
                        own_state_r <= OWN0;
                    end
                end
                OWN1: begin
                    if (gnt1 && !lock1) begin
                        own_state_r <= FREE;
                    end else begin
                        own_state_r <= OWN1;
                    end
                end
                default: own_state_r <= FREE;
            endcase
        end
    end
`else
    logic unused_lock_s;
    assign unused_lock_s = lock0 ^ lock1;

    // Without locking, requests reach the arbiter untouched
    always_comb begin
        req0_s = req0;
        req1_s = req1;
    end
`endif

    // Combinational grant: single requester wins outright, ties alternate
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_s && req1_s) begin
            if (rr_winner(rr_last_r) == REQ_M0) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0_s;
            gnt1 = req1_s;
        end
    end

    // Remember the most recent winner; reset value makes m0 win the first tie
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rr_last_r <= REQ_M1;
        end else if (gnt0) begin
            rr_last_r <= REQ_M0;
        end else if (gnt1) begin
            rr_last_r <= REQ_M1;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of one Block_RAM (write port A, read port B).
// Define BRAM_ARB_LOCK_EN to honour the m*_lock inputs.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_lock,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_lock,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ADDR_W-1:0]   bram_waddr,
    output logic [DATA_W-1:0]   bram_wdata,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_raddr,
    input  logic [DATA_W-1:0]   bram_rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic              acc_s;
    logic              sel_id_s;
    logic              sel_write_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [STRB_W-1:0] sel_wstrb_s;
    logic              rd_tag_vld_r;
    logic              rd_tag_id_r;

    bram_arb_rr2 u_rr2 (
        .clk   (clk),
        .RSTn  (RSTn),
        .req0  (m0_valid),
        .req1  (m1_valid),
        .lock0 (m0_lock),
        .lock1 (m1_lock),
        .gnt0  (m0_ready),
        .gnt1  (m1_ready)
    );

    // Select the command of whichever requester was granted this cycle
    always_comb begin
        acc_s = m0_ready | m1_ready;
        if (m1_ready) begin
            sel_id_s    = REQ_M1;
            sel_write_s = m1_write;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
            sel_wstrb_s = m1_wstrb;
        end else begin
            sel_id_s    = REQ_M0;
            sel_write_s = m0_write;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
            sel_wstrb_s = m0_wstrb;
        end
    end

    // Issue stage: drive the RAM ports and tag reads with their owner
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            bram_we      <= {STRB_W{1'b0}};
            bram_waddr   <= {ADDR_W{1'b0}};
            bram_wdata   <= {DATA_W{1'b0}};
            bram_raddr   <= {ADDR_W{1'b0}};
            rd_tag_vld_r <= 1'b0;
            rd_tag_id_r  <= REQ_M0;
        end else if (acc_s && sel_write_s) begin
            bram_we      <= sel_wstrb_s;
            bram_waddr   <= sel_addr_s;
            bram_wdata   <= sel_wdata_s;
            rd_tag_vld_r <= 1'b0;
        end else if (acc_s) begin
            bram_we      <= {STRB_W{1'b0}};
            bram_raddr   <= sel_addr_s;
            rd_tag_vld_r <= 1'b1;
            rd_tag_id_r  <= sel_id_s;
        end else begin
            bram_we      <= {STRB_W{1'b0}};
            rd_tag_vld_r <= 1'b0;
        end
    end

    // Response stage: the RAM's doutb is valid one cycle after the tag
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= rd_tag_vld_r && (rd_tag_id_r == REQ_M0);
            m1_rvalid <= rd_tag_vld_r && (rd_tag_id_r == REQ_M1);
        end
    end

    assign m0_rdata = bram_rdata;
    assign m1_rdata = bram_rdata;

endmodule
